imm_encoder: RTL and testbench



---
 rtl/imm_pkg.sv | 39 +++
 rtl/imm_encoder_if.sv | 23 ++
 rtl/imm_rot_check.sv | 20 ++
 rtl/imm_encoder.sv | 143 ++++++++++++++
 tb/tb_imm_encoder.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/imm_pkg.sv
// Shared constants, state type and fixed-format encode helper for imm_encoder.
// Build option: IMM_ENC_PARALLEL_EN selects single-cycle rotation search.
package imm_pkg;

    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;
    localparam logic [1:0] IMM_RSV = 2'b11;

    localparam int IMM_ROT_MAX = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEARCH,
        S_FINISH
    } imm_enc_state_t;

    // Returns {ok, imm} for the non-rotating classes.
    function automatic logic [24:0] fixed_enc(
        input logic [1:0]  src,
        input logic [31:0] v
    );
        logic [24:0] res;
        res = '0;
        case (src)
            IMM_MEM: begin
                if (v[31:12] == '0)
                    res = {1'b1, 12'b0, v[11:0]};
            end
            IMM_BR: begin
                if (v[1:0] == 2'b00 && v[31:25] == {7{v[25]}})
                    res = {1'b1, v[25:2]};
            end
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Request/result bundle between the instruction generator and imm_encoder.
// Build option: none.
interface imm_encoder_if;

    logic        start;
    logic [1:0]  ImmSrc;
    logic [31:0] Value;
    logic        busy;
    logic        done;
    logic        ok;
    logic [23:0] Imm;

    modport master (
        output start, ImmSrc, Value,
        input  busy, done, ok, Imm
    );

    modport slave (
        input  start, ImmSrc, Value,
        output busy, done, ok, Imm
    );

endinterface

// File: rtl/imm_rot_check.sv
// Tests whether value rotated left by 2*r fits in an 8-bit immediate.
// Build option: none.
module imm_rot_check (
    input  logic [31:0] value,
    input  logic [3:0]  r,
    output logic        fits,
    output logic [7:0]  imm8
);

    logic [4:0]  sh;
    logic [63:0] dbl;
    logic [31:0] c;

    assign sh   = {r, 1'b0};
    assign dbl  = {value, value} << sh;
    assign c    = dbl[63:32];
    assign fits = (c[31:8] == '0);
    assign imm8 = c[7:0];

endmodule

// File: rtl/imm_encoder.sv
// Inverse immediate extender: constant + ImmSrc -> 24-bit field or unencodable.
// Build option: IMM_ENC_PARALLEL_EN evaluates all rotations in one cycle.
module imm_encoder
    import imm_pkg::*;
#(
    parameter int ROT_STEPS = 16
) (
    input  logic          clk,
    input  logic          reset,
    imm_encoder_if.slave  bus
);

    imm_enc_state_t state, state_n;
    logic [3:0]  r, r_n;
    logic [31:0] val, val_n;
    logic [1:0]  src, src_n;
    logic        busy, busy_n;
    logic        done, done_n;
    logic        ok, ok_n;
    logic [23:0] imm, imm_n;
    logic        dp_fits;
    logic [23:0] dp_imm;
    logic        last;

    assign last = (r == 4'(ROT_STEPS - 1));

`ifdef IMM_ENC_PARALLEL_EN
    localparam bit PAR = 1'b1;
    logic [ROT_STEPS-1:0] fits_a;
    logic [7:0]           imm8_a [ROT_STEPS];

    for (genvar g = 0; g < ROT_STEPS; g++) begin : g_rot
        imm_rot_check u_rot (
            .value (val),
            .r     (4'(g)),
            .fits  (fits_a[g]),
            .imm8  (imm8_a[g])
        );
    end

    // Descending scan so the lowest fitting r is the final winner.
    always_comb begin
        dp_fits = 1'b0;
        dp_imm  = '0;
        for (int i = ROT_STEPS - 1; i >= 0; i--) begin
            if (fits_a[i]) begin
                dp_fits = 1'b1;
                dp_imm  = {12'b0, 4'(i), imm8_a[i]};
            end
        end
    end
`else
    localparam bit PAR = 1'b0;
    logic [7:0] imm8;

    imm_rot_check u_rot (
        .value (val),
        .r     (r),
        .fits  (dp_fits),
        .imm8  (imm8)
    );

    assign dp_imm = {12'b0, r, imm8};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            r     <= '0;
            val   <= '0;
            src   <= IMM_DP;
            busy  <= 1'b0;
            done  <= 1'b0;
            ok    <= 1'b0;
            imm   <= '0;
        end else begin
            state <= state_n;
            r     <= r_n;
            val   <= val_n;
            src   <= src_n;
            busy  <= busy_n;
            done  <= done_n;
            ok    <= ok_n;
            imm   <= imm_n;
        end
    end

    always_comb begin
        state_n = state;
        r_n     = r;
        val_n   = val;
        src_n   = src;
        busy_n  = busy;
        done_n  = 1'b0;
        ok_n    = ok;
        imm_n   = imm;
        unique case (state)
            S_IDLE: begin
                if (bus.start) begin
                    val_n  = bus.Value;
                    src_n  = bus.ImmSrc;
                    busy_n = 1'b1;
                    ok_n   = 1'b0;
                    r_n    = '0;
                    if (bus.ImmSrc == IMM_DP && !PAR)
                        state_n = S_SEARCH;
                    else
                        state_n = S_FINISH;
                end
            end
            // A hit or the final miss resolves on the same edge it is seen.
            S_SEARCH: begin
                if (dp_fits || last) begin
                    ok_n    = dp_fits;
                    imm_n   = dp_fits ? dp_imm : '0;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = S_IDLE;
                end else begin
                    r_n = r + 4'd1;
                end
            end
            S_FINISH: begin
                if (src == IMM_DP) begin
                    ok_n  = dp_fits;
                    imm_n = dp_fits ? dp_imm : '0;
                end else begin
                    {ok_n, imm_n} = fixed_enc(src, val);
                end
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.ok   = ok;
    assign bus.Imm  = imm;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed checks of imm_encoder against a latency/result model.
// Build option: IMM_ENC_PARALLEL_EN changes expected DP latency to 1.
module tb_imm_encoder;

    localparam int ROT = 16;
    localparam logic [1:0] DP  = 2'b00;
    localparam logic [1:0] MEM = 2'b01;
    localparam logic [1:0] BR  = 2'b10;
    localparam logic [1:0] RSV = 2'b11;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    imm_encoder_if bus ();

    imm_encoder #(.ROT_STEPS(ROT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Expander direction, used for round-trip checks.
    function automatic logic [31:0] ext(input logic [1:0] s,
                                        input logic [23:0] f);
        logic [31:0] b;
        int          a;
        b = {24'b0, f[7:0]};
        a = 2 * f[11:8];
        case (s)
            DP:      return (b >> a) | (b << (32 - a));
            MEM:     return {20'b0, f[11:0]};
            default: return {{6{f[23]}}, f, 2'b00};
        endcase
    endfunction

    // Returns {lat[6:0], ok, imm} from the encoding rules.
    function automatic logic [31:0] model(input logic [1:0] s,
                                          input logic [31:0] v);
        logic [31:0] c;
        int          sv;
        if (s == DP) begin
            for (int r = 0; r < ROT; r++) begin
                c = (v << (2 * r)) | (v >> (32 - 2 * r));
                if (c < 256) begin
`ifdef IMM_ENC_PARALLEL_EN
                    return {7'd1, 1'b1, 12'b0, 4'(r), c[7:0]};
`else
                    return {7'(r + 1), 1'b1, 12'b0, 4'(r), c[7:0]};
`endif
                end
            end
`ifdef IMM_ENC_PARALLEL_EN
            return {7'd1, 25'b0};
`else
            return {7'(ROT), 25'b0};
`endif
        end
        if (s == MEM) begin
            if (v < 4096) return {7'd1, 1'b1, 12'b0, v[11:0]};
            return {7'd1, 25'b0};
        end
        if (s == BR) begin
            sv = $signed(v);
            if (v % 4 == 0 && sv >= -(1 << 25) && sv < (1 << 25))
                return {7'd1, 1'b1, v[25:2]};
            return {7'd1, 25'b0};
        end
        return {7'd1, 25'b0};
    endfunction

    logic        m_busy, m_done, m_ok;
    logic [23:0] m_imm;
    logic [31:0] m_res;
    int          m_cnt;

    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_ok   <= 1'b0;
            m_imm  <= '0;
            m_cnt  <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_cnt == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_ok   <= m_res[24];
                    m_imm  <= m_res[23:0];
                end
                m_cnt <= m_cnt - 1;
            end else if (bus.start) begin
                m_res  <= model(bus.ImmSrc, bus.Value);
                m_cnt  <= int'(model(bus.ImmSrc, bus.Value) >> 25);
                m_busy <= 1'b1;
                m_ok   <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", 32'(bus.busy), 32'(m_busy));
        chk("done", 32'(bus.done), 32'(m_done));
        chk("ok", 32'(bus.ok), 32'(m_ok));
        chk("imm", 32'(bus.Imm), 32'(m_imm));
    end

    // Issues one request now (between edges); returns #1 after done.
    task automatic run(input logic [1:0] s, input logic [31:0] v,
                       input logic eok, input logic [23:0] eimm,
                       input int elat, input int poke);
        int n;
        bus.start  = 1'b1;
        bus.ImmSrc = s;
        bus.Value  = v;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.ImmSrc = ~s;
        bus.Value  = ~v;
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (poke != 0 && n == poke) bus.start = 1'b0;
            if (bus.done) break;
            if (poke != 0 && n == poke - 1) begin
                bus.start  = 1'b1;
                bus.ImmSrc = DP;
                bus.Value  = 32'h0000_00FF;
            end
        end
        bus.start = 1'b0;
        chk($sformatf("lat %h", v), n, elat);
        chk($sformatf("ok %h", v), 32'(bus.ok), 32'(eok));
        chk($sformatf("imm %h", v), 32'(bus.Imm), 32'(eimm));
        if (eok)
            chk($sformatf("trip %h", v), ext(s, bus.Imm), v);
    endtask

    int dlat;

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.start  = 1'b0;
        bus.ImmSrc = DP;
        bus.Value  = '0;
`ifdef IMM_ENC_PARALLEL_EN
        dlat = 1;
`else
        dlat = 0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst done", 32'(bus.done), 32'd0);
        chk("rst ok", 32'(bus.ok), 32'd0);
        chk("rst imm", 32'(bus.Imm), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run(DP, 32'h0000_00FF, 1'b1, 24'h0000FF, 1, 0);
        run(DP, 32'hFF00_0000, 1'b1, 24'h0004FF, dlat ? 1 : 5, 0);
        run(DP, 32'h0000_0101, 1'b0, 24'h000000, dlat ? 1 : 16, dlat ? 0 : 3);
        @(negedge clk);
        run(DP, 32'hF000_000F, 1'b1, 24'h0002FF, dlat ? 1 : 3, 0);
        run(DP, 32'h0000_03FC, 1'b1, 24'h000FFF, dlat ? 1 : 16, 0);
        run(MEM, 32'h0000_0ABC, 1'b1, 24'h000ABC, 1, 0);
        run(MEM, 32'h0000_1000, 1'b0, 24'h000000, 1, 0);
        run(BR, 32'hFFFF_FFF8, 1'b1, 24'hFFFFFE, 1, 0);
        run(BR, 32'h0000_0006, 1'b0, 24'h000000, 1, 0);
        run(BR, 32'h0200_0000, 1'b0, 24'h000000, 1, 0);
        run(RSV, 32'h0000_0000, 1'b0, 24'h000000, 1, 0);

        @(negedge clk);
        bus.start  = 1'b1;
        bus.ImmSrc = DP;
        bus.Value  = 32'h0000_0101;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("mid busy", 32'(bus.busy), 32'd0);
        chk("mid ok", 32'(bus.ok), 32'd0);
        chk("mid imm", 32'(bus.Imm), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        run(DP, 32'h0000_00FF, 1'b1, 24'h0000FF, 1, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
